// File: rtl/kernel_mem_ctrl.sv
// rtl/kernel_mem_ctrl.sv - load/stream sequencer for one memBlockKernel
//
// Loads a kernel into memBlockKernel as alternating half-rows from a
// cacheline stream, then replays the loaded rows rd_repeat times with
// valid/last flags aligned to the RAM's 1-cycle read latency.
//
// Ports:
//   clk, reset (async, active-low)
//   load_start/load_rows             load command
//   in_valid/in_ready/in_data        cacheline stream in
//   load_done, kernel_loaded         load status
//   rd_start/rd_repeat               stream command
//   out_valid/out_last/stream_done   stream flags for the MAC array
//   cmd_err, busy                    command status
//   mem_we/mem_select/mem_write_address/mem_read_address/mem_in_data
//                                    memBlockKernel drive
module kernel_mem_ctrl #(
    parameter int ADDR_WIDTH   = 9,
    parameter int LINE_WIDTH   = 512,
    parameter int REPEAT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic [ADDR_WIDTH:0]     load_rows,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LINE_WIDTH-1:0]   in_data,
    output logic                    load_done,
    output logic                    kernel_loaded,
    input  logic                    rd_start,
    input  logic [REPEAT_WIDTH-1:0] rd_repeat,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    stream_done,
    output logic                    cmd_err,
    output logic                    busy,
    output logic                    mem_we,
    output logic                    mem_select,
    output logic [ADDR_WIDTH-1:0]   mem_write_address,
    output logic [ADDR_WIDTH-1:0]   mem_read_address,
    output logic [LINE_WIDTH-1:0]   mem_in_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH:0]     MAX_ROWS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]     ONE_ROW  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]   ONE_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REPEAT_WIDTH-1:0] ONE_PASS = {{(REPEAT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    // One bit wider than the address so a full 2**ADDR_WIDTH-row load
    // can count past the last row without wrapping.
    logic [ADDR_WIDTH:0]     row_cnt;
    logic [ADDR_WIDTH:0]     rows_cfg;
    logic                    half;
    logic [REPEAT_WIDTH-1:0] passes_left;
    logic                    wr_final;

    logic                    load_ok;
    logic                    rd_ok;
    logic                    beat;
    logic                    final_beat;
    logic [ADDR_WIDTH:0]     last_row;
    logic                    is_stream;
    logic                    at_last_row;
    logic                    last_pass;

    assign busy      = (state == S_LOAD) || (state == S_STREAM) || (state == S_DRAIN);
    assign in_ready  = (state == S_LOAD);
    assign is_stream = (state == S_STREAM);
    assign last_row  = rows_cfg - ONE_ROW;

    assign load_ok = load_start && !busy && (load_rows != '0) && (load_rows <= MAX_ROWS);
    // A simultaneous load_start takes priority, so rd_start is refused then.
    assign rd_ok   = rd_start && !load_start && (state == S_LOADED) && (rd_repeat != '0);

    assign beat        = in_ready && in_valid;
    assign final_beat  = beat && half && (row_cnt == last_row);
    assign at_last_row = ({1'b0, mem_read_address} == last_row);
    assign last_pass   = (passes_left == ONE_PASS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (load_ok) state_nxt = S_LOAD;
            S_LOAD:   if (final_beat) state_nxt = S_LOADED;
            S_LOADED: begin
                if (load_ok) begin
                    state_nxt = S_LOAD;
                end else if (rd_ok) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: if (at_last_row && last_pass) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_LOADED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt           <= '0;
            rows_cfg          <= '0;
            half              <= 1'b0;
            passes_left       <= '0;
            wr_final          <= 1'b0;
            load_done         <= 1'b0;
            kernel_loaded     <= 1'b0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            stream_done       <= 1'b0;
            cmd_err           <= 1'b0;
            mem_we            <= 1'b0;
            mem_select        <= 1'b0;
            mem_write_address <= '0;
            mem_read_address  <= '0;
            mem_in_data       <= '0;
        end else begin
            cmd_err  <= (load_start && !load_ok) || (rd_start && !rd_ok);

            // Write side: one registered write per accepted beat.
            mem_we   <= beat;
            wr_final <= final_beat;
            // load_done lands one cycle after the final write cycle.
            load_done <= wr_final;
            if (beat) begin
                mem_in_data       <= in_data;
                mem_select        <= half;
                mem_write_address <= row_cnt[ADDR_WIDTH-1:0];
                half              <= ~half;
                if (half) begin
                    row_cnt <= row_cnt + ONE_ROW;
                end
            end
            if (load_ok) begin
                row_cnt       <= '0;
                half          <= 1'b0;
                rows_cfg      <= load_rows;
                kernel_loaded <= 1'b0;
            end else if (wr_final) begin
                kernel_loaded <= 1'b1;
            end

            // Read side: the address register is the address phase; the
            // flags below are that phase delayed one cycle to match the RAM.
            out_valid   <= is_stream;
            out_last    <= is_stream && at_last_row;
            stream_done <= is_stream && at_last_row && last_pass;
            if (rd_ok) begin
                mem_read_address <= '0;
                passes_left      <= rd_repeat;
            end else if (is_stream) begin
                if (at_last_row) begin
                    mem_read_address <= '0;
                    passes_left      <= passes_left - ONE_PASS;
                end else begin
                    mem_read_address <= mem_read_address + ONE_ADDR;
                end
            end
        end
    end

endmodule
